icache_line_fill: RTL and testbench

//  Line-fill engine between the instruction cache and physical memory. Accepts a
//  256-bit line read request from the icache control, issues one 4-beat x 64-bit

---
 rtl/icache_line_fill.sv | 91 +++++++++
 tb/tb_icache_line_fill.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill.sv
// Line-fill engine: turns one icache line read into a 4-beat burst read and
// assembles the returned beats into a full line with a one-cycle pmem_resp.
module icache_line_fill #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_beat   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              burst_read,
  output logic [31:0]       burst_addr,
  input  logic [s_beat-1:0] burst_rdata,
  input  logic              burst_resp
);
  localparam int n_beats = s_line / s_beat;
  localparam int cnt_w   = $clog2(n_beats);
  localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t              state_q, state_d;
  logic [cnt_w-1:0]    beat_cnt_q, beat_cnt_d;
  logic                burst_read_q, burst_read_d;
  logic [31:0]         burst_addr_q, burst_addr_d;
  logic                pmem_resp_q, pmem_resp_d;
  logic [s_line-1:0]   pmem_rdata_q, pmem_rdata_d;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    burst_read_d = burst_read_q;
    burst_addr_d = burst_addr_q;
    pmem_rdata_d = pmem_rdata_q;
    pmem_resp_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pmem_read) begin
          burst_addr_d = pmem_address & line_mask;
          beat_cnt_d   = '0;
          burst_read_d = 1'b1;
          state_d      = READ;
        end
      end
      READ: begin
        if (burst_resp) begin
          for (int i = 0; i < n_beats; i++)
            if (beat_cnt_q == cnt_w'(i)) pmem_rdata_d[i*s_beat +: s_beat] = burst_rdata;
          // Counter wraps to 0 on the last beat, ready for the next fill.
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == cnt_w'(n_beats - 1)) begin
            burst_read_d = 1'b0;
            pmem_resp_d  = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        burst_read_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      burst_read_q <= 1'b0;
      burst_addr_q <= '0;
      pmem_resp_q  <= 1'b0;
      pmem_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_read_q <= burst_read_d;
      burst_addr_q <= burst_addr_d;
      pmem_resp_q  <= pmem_resp_d;
      pmem_rdata_q <= pmem_rdata_d;
    end
  end

  assign pmem_rdata = pmem_rdata_q;
  assign pmem_resp  = pmem_resp_q;
  assign burst_read = burst_read_q;
  assign burst_addr = burst_addr_q;
endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: per-cycle vector table for the basic
// fill, gapped fill and idle-beat cases, plus hand sequences for the rest.
module tb_icache_line_fill;
  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         burst_read;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  icache_line_fill dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .burst_read(burst_read),
    .burst_addr(burst_addr), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_bursts = 0;
  int n_resps = 0;
  logic prev_br = 1'b0;

  always @(posedge clk) begin
    if (burst_read && !prev_br) n_bursts++;
    if (pmem_resp) n_resps++;
    prev_br <= burst_read;
  end

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] Z  = 64'h0;

  typedef struct {
    logic         rd;
    logic [31:0]  addr;
    logic         bresp;
    logic [63:0]  bdata;
    logic         e_br;
    logic [31:0]  e_ba;
    logic         e_resp;
    logic [255:0] e_line;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rd, logic [31:0] addr, logic bresp, logic [63:0] bdata,
                              logic e_br, logic [31:0] e_ba, logic e_resp, logic [255:0] e_line);
    vec_t v;
    v.rd = rd; v.addr = addr; v.bresp = bresp; v.bdata = bdata;
    v.e_br = e_br; v.e_ba = e_ba; v.e_resp = e_resp; v.e_line = e_line;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_br, input logic [31:0] e_ba,
                         input logic e_resp, input logic [255:0] e_line);
    chk({tag, ".burst_read"}, 256'(burst_read), 256'(e_br));
    chk({tag, ".burst_addr"}, 256'(burst_addr), 256'(e_ba));
    chk({tag, ".pmem_resp"},  256'(pmem_resp),  256'(e_resp));
    chk({tag, ".pmem_rdata"}, pmem_rdata, e_line);
  endtask

  task automatic drive(input logic rd, input logic [31:0] addr, input logic br, input logic [63:0] bd);
    pmem_read = rd; pmem_address = addr; burst_resp = br; burst_rdata = bd;
  endtask

  int nb0, nr0;

  initial begin
    logic [255:0] l1, c_line, d_line, e_line;
    l1 = {B3, B2, B1, B0};
    drive(1'b0, 32'h0, 1'b0, 64'h0);
    rst = 1'b1;
    #12;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: consecutive beats; test 6: beats while idle; test 2: gapped beats.
    vt.push_back(mk(1, 32'h1234, 0, Z,  1, 32'h1220, 0, 256'h0));
    vt.push_back(mk(1, 32'h1234, 0, Z,  1, 32'h1220, 0, 256'h0));
    vt.push_back(mk(1, 32'h1234, 1, B0, 1, 32'h1220, 0, {Z, Z, Z, B0}));
    vt.push_back(mk(1, 32'h1234, 1, B1, 1, 32'h1220, 0, {Z, Z, B1, B0}));
    vt.push_back(mk(1, 32'h1234, 1, B2, 1, 32'h1220, 0, {Z, B2, B1, B0}));
    vt.push_back(mk(1, 32'h1234, 1, B3, 0, 32'h1220, 1, l1));
    vt.push_back(mk(0, 32'h1234, 0, Z,  0, 32'h1220, 0, l1));
    vt.push_back(mk(0, 32'hFFFF_FFFF, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 32'h1220, 0, l1));
    vt.push_back(mk(0, 32'hFFFF_FFFF, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 32'h1220, 0, l1));
    vt.push_back(mk(1, 32'h1234, 0, Z,  1, 32'h1220, 0, l1));
    vt.push_back(mk(1, 32'h1234, 0, Z,  1, 32'h1220, 0, l1));
    vt.push_back(mk(1, 32'h1234, 1, B0, 1, 32'h1220, 0, l1));
    vt.push_back(mk(1, 32'h1234, 1, B1, 1, 32'h1220, 0, l1));
    vt.push_back(mk(1, 32'h1234, 0, Z,  1, 32'h1220, 0, l1));
    vt.push_back(mk(1, 32'h1234, 0, Z,  1, 32'h1220, 0, l1));
    vt.push_back(mk(1, 32'h1234, 1, B2, 1, 32'h1220, 0, l1));
    vt.push_back(mk(1, 32'h1234, 1, B3, 0, 32'h1220, 1, l1));
    vt.push_back(mk(0, 32'h1234, 0, Z,  0, 32'h1220, 0, l1));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rd, vt[i].addr, vt[i].bresp, vt[i].bdata);
      step();
      chk_out($sformatf("vec%0d", i), vt[i].e_br, vt[i].e_ba, vt[i].e_resp, vt[i].e_line);
    end

    // Test 3: back-to-back requests with pmem_read held through DONE.
    c_line = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    d_line = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    nb0 = n_bursts; nr0 = n_resps;
    drive(1, 32'h100, 0, Z); step();
    chk_out("b2b.req1", 1, 32'h100, 0, l1);
    for (int i = 0; i < 4; i++) begin drive(1, 32'h100, 1, 64'(8'hC0 + i)); step(); end
    chk_out("b2b.done1", 0, 32'h100, 1, c_line);
    drive(1, 32'h200, 0, Z); step();
    chk_out("b2b.idle", 0, 32'h100, 0, c_line);
    step();
    chk_out("b2b.req2", 1, 32'h200, 0, c_line);
    for (int i = 0; i < 4; i++) begin drive(1, 32'h200, 1, 64'(8'hD0 + i)); step(); end
    chk_out("b2b.done2", 0, 32'h200, 1, d_line);
    drive(0, 32'h200, 0, Z); step(); step();
    chk("b2b.bursts", 256'(n_bursts - nb0), 256'd2);
    chk("b2b.resps",  256'(n_resps - nr0),  256'd2);

    // Test 4: pmem_read dropped after the first beat.
    nb0 = n_bursts; nr0 = n_resps;
    drive(1, 32'h3000, 0, Z); step();
    drive(1, 32'h3000, 1, 64'hA0); step();
    for (int i = 1; i < 4; i++) begin drive(0, 32'h3000, 1, 64'(8'hA0 + i)); step(); end
    chk_out("drop.done", 0, 32'h3000, 1, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    drive(0, 32'h3000, 0, Z); step(); step(); step();
    chk_out("drop.idle", 0, 32'h3000, 0, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    chk("drop.bursts", 256'(n_bursts - nb0), 256'd1);
    chk("drop.resps",  256'(n_resps - nr0),  256'd1);

    // Test 5: reset mid-burst, then a clean fill.
    drive(1, 32'h4040, 0, Z); step();
    drive(1, 32'h4040, 1, 64'hB0); step();
    drive(1, 32'h4040, 1, 64'hB1); step();
    drive(0, 32'h4040, 0, Z);
    rst = 1'b1;
    #1;
    chk_out("rst.mid", 0, 32'h0, 0, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_out("rst.after", 0, 32'h0, 0, 256'h0);
    e_line = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    drive(1, 32'h5678, 0, Z); step();
    chk_out("rst.req", 1, 32'h5660, 0, 256'h0);
    drive(1, 32'h5678, 1, 64'hE0); step();
    chk_out("rst.beat0", 1, 32'h5660, 0, {Z, Z, Z, 64'hE0});
    for (int i = 1; i < 4; i++) begin drive(1, 32'h5678, 1, 64'(8'hE0 + i)); step(); end
    chk_out("rst.done", 0, 32'h5660, 1, e_line);
    drive(0, 32'h0, 0, Z); step();
    chk_out("rst.idle", 0, 32'h5660, 0, e_line);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
